id_operand_stage: RTL and testbench

//  Decode-stage operand issue unit between fetch and execute. Drives regfile read addresses and

---
 rtl/id_pkg.sv | 57 +++++
 rtl/id_operand_stage_scoreboard.sv | 65 ++++++
 rtl/id_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_operand_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID operand stage: opcode map and the
// per-opcode operand/destination usage helpers.
package id_pkg;

    // Default datapath / PC width.
    localparam int XLEN_DEFAULT = 32;

    // RV32I major opcodes, instruction bits [6:2].
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // Decoded register usage of one instruction.
    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_rd;
    } reg_use_t;

    // rs1 is read by everything except the upper-immediate forms and JAL.
    function automatic logic uses_rs1(input logic [4:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    // rs2 is read only by compares, stores and register-register ALU ops.
    function automatic logic uses_rs2(input logic [4:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
    endfunction

    // Opcodes that produce a register result (rd==x0 filtered by the caller).
    function automatic logic writes_rd(input logic [4:0] opc);
        logic w;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: w = 1'b1;
            default:                                   w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic reg_use_t decode_use(input logic [4:0] opc);
        reg_use_t u;
        u.use_rs1 = uses_rs1(opc);
        u.use_rs2 = uses_rs2(opc);
        u.wr_rd   = writes_rd(opc);
        return u;
    endfunction

endpackage

// File: rtl/id_operand_stage_scoreboard.sv
// Counting scoreboard: one PEND_W-bit outstanding-write counter per
// architectural register x1..x31 (x0 never pends).
module reg_scoreboard
    import id_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic                  clk_i,
    input  logic                  n_rst,
    input  logic                  inc_en_i,
    input  logic [4:0]            inc_rd_i,
    input  logic                  dec_en_i,
    input  logic [4:0]            dec_rd_i,
    output logic [32*PEND_W-1:0]  pend_o,
    output logic                  err_o
);

    localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] ZERO = '0;

    logic [PEND_W-1:0] pend_q [1:31];
    logic [PEND_W-1:0] pend_d [1:31];

    // Next-state counters and the write-without-pending error pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        err_o = 1'b0;
        for (int r = 1; r < 32; r++) begin
            pend_d[r] = pend_q[r];
            if (inc_en_i && inc_rd_i == 5'(r) && !(dec_en_i && dec_rd_i == 5'(r))) begin
                pend_d[r] = pend_q[r] + ONE;
            end else if (dec_en_i && dec_rd_i == 5'(r) && !(inc_en_i && inc_rd_i == 5'(r))) begin
                if (pend_q[r] == ZERO) begin
                    err_o = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - ONE;
                end
            end
        end
    end

    // Counter state; cleared asynchronously.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: this register array is reset explicitly; a stale pending count after reset would stall issue forever.
            for (int r = 1; r < 32; r++) begin
                pend_q[r] <= ZERO;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every counter samples pre-edge values.
            for (int r = 1; r < 32; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    // Flatten counters into a vector, x0 slot tied to zero.
    always_comb begin
        pend_o[PEND_W-1:0] = ZERO;
        for (int r = 1; r < 32; r++) begin
            pend_o[r*PEND_W +: PEND_W] = pend_q[r];
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand issue: register read, writeback bypass, RAW and
// saturation stalls against the scoreboard, and the ID/EX slot.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int PEND_W = 2
) (
    input  logic            clk_i,
    input  logic            n_rst,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            flush_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [31:0]     ex_instr_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_rd_we_o,
    output logic            sb_err_o
);

    // Counter arithmetic is one bit wider so the in-slot writer can be added without wrap.
    localparam int            CW      = PEND_W + 1;
    localparam logic [CW-1:0] SAT_MAX = CW'((1 << PEND_W) - 1);

    // ID/EX slot
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q,    ex_pc_d;
    logic [31:0]     ex_instr_q, ex_instr_d;
    logic [XLEN-1:0] ex_rs1_q,   ex_rs1_d;
    logic [XLEN-1:0] ex_rs2_q,   ex_rs2_d;
    logic [4:0]      ex_rd_q,    ex_rd_d;
    logic            ex_rd_we_q, ex_rd_we_d;
    logic            sb_err_q,   sb_err_d;

    // Decode
    logic [4:0] rs1, rs2, rd;
    reg_use_t   use_info;
    logic       rd_we;

    // Scoreboard interface
    logic [32*PEND_W-1:0] pend_vec;
    logic [PEND_W-1:0]    pend [32];
    logic                 sb_inc_en, sb_dec_en, sb_err_pulse;

    // Hazard / bypass
    logic          ex_hit_rs1, ex_hit_rs2, ex_hit_rd;
    logic          wb_hit_rs1, wb_hit_rs2;
    logic [CW-1:0] sum_rs1, sum_rs2, sum_rd;
    logic          raw_hz, sat_hz, slot_free, accept;

    assign rs1      = if_instr_i[19:15];
    assign rs2      = if_instr_i[24:20];
    assign rd       = if_instr_i[11:7];
    assign use_info = decode_use(if_instr_i[6:2]);
    assign rd_we    = use_info.wr_rd && (rd != 5'd0);

    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    // A slot handshake that coincides with a flush belongs to squashed work and is not counted.
    assign sb_inc_en = ex_valid_q && ex_ready_i && ex_rd_we_q && !flush_i;
    assign sb_dec_en = wb_we_i && (wb_rd_i != 5'd0);

    reg_scoreboard #(.PEND_W(PEND_W)) u_sb (
        .clk_i    (clk_i),
        .n_rst    (n_rst),
        .inc_en_i (sb_inc_en),
        .inc_rd_i (ex_rd_q),
        .dec_en_i (sb_dec_en),
        .dec_rd_i (wb_rd_i),
        .pend_o   (pend_vec),
        .err_o    (sb_err_pulse)
    );

    // Unpack scoreboard counters for register-indexed lookup.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend[r] = pend_vec[r*PEND_W +: PEND_W];
        end
    end

    // RAW and saturation hazards plus the issue handshake.
    always_comb begin
        ex_hit_rs1 = ex_valid_q && ex_rd_we_q && (ex_rd_q == rs1);
        ex_hit_rs2 = ex_valid_q && ex_rd_we_q && (ex_rd_q == rs2);
        ex_hit_rd  = ex_valid_q && ex_rd_we_q && (ex_rd_q == rd);
        wb_hit_rs1 = wb_we_i && (wb_rd_i == rs1);
        wb_hit_rs2 = wb_we_i && (wb_rd_i == rs2);

        sum_rs1 = CW'(pend[rs1]) + CW'(ex_hit_rs1);
        sum_rs2 = CW'(pend[rs2]) + CW'(ex_hit_rs2);
        sum_rd  = CW'(pend[rd])  + CW'(ex_hit_rd);

        // Effective pending count is zero exactly when this cycle's writeback retires the last writer.
        raw_hz = (use_info.use_rs1 && rs1 != 5'd0 && sum_rs1 != CW'(wb_hit_rs1)) ||
                 (use_info.use_rs2 && rs2 != 5'd0 && sum_rs2 != CW'(wb_hit_rs2));
        sat_hz = rd_we && (sum_rd == SAT_MAX);

        slot_free  = !ex_valid_q || ex_ready_i;
        if_ready_o = slot_free && !raw_hz && !sat_hz && !flush_i;
        accept     = if_valid_i && if_ready_o;
    end

    // Next-state of the ID/EX slot with writeback bypass on operand capture.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_instr_d = ex_instr_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        sb_err_d   = sb_err_q || sb_err_pulse;

        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            ex_pc_d    = if_pc_i;
            ex_instr_d = if_instr_i;
            ex_rd_d    = rd_we ? rd : 5'd0;
            ex_rd_we_d = rd_we;

            if (!use_info.use_rs1)              ex_rs1_d = '0;
            else if (wb_hit_rs1 && rs1 != 5'd0) ex_rs1_d = wb_data_i;
            else                                ex_rs1_d = rs1_data_i;

            if (!use_info.use_rs2)              ex_rs2_d = '0;
            else if (wb_hit_rs2 && rs2 != 5'd0) ex_rs2_d = wb_data_i;
            else                                ex_rs2_d = rs2_data_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX slot and sticky scoreboard error registers.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_instr_q <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
            sb_err_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_instr_q <= ex_instr_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign ex_pc_o    = ex_pc_q;
    assign ex_instr_o = ex_instr_q;
    assign ex_rs1_o   = ex_rs1_q;
    assign ex_rs2_o   = ex_rs2_q;
    assign ex_rd_o    = ex_rd_q;
    assign ex_rd_we_o = ex_rd_we_q;
    assign sb_err_o   = sb_err_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: issue, bypass, stall, saturation,
// flush, scoreboard error and asynchronous reset.
module tb_id_operand_stage;

    logic        clk_i = 1'b0;
    logic        n_rst;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        flush_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_pc_o, ex_instr_o, ex_rs1_o, ex_rs2_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rd_we_o;
    logic        sb_err_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    id_operand_stage #(.XLEN(32), .PEND_W(2)) dut (
        .clk_i      (clk_i),
        .n_rst      (n_rst),
        .if_valid_i (if_valid_i),
        .if_ready_o (if_ready_o),
        .if_instr_i (if_instr_i),
        .if_pc_i    (if_pc_i),
        .flush_i    (flush_i),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .wb_we_i    (wb_we_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .ex_valid_o (ex_valid_o),
        .ex_ready_i (ex_ready_i),
        .ex_pc_o    (ex_pc_o),
        .ex_instr_o (ex_instr_o),
        .ex_rs1_o   (ex_rs1_o),
        .ex_rs2_o   (ex_rs2_o),
        .ex_rd_o    (ex_rd_o),
        .ex_rd_we_o (ex_rd_we_o),
        .sb_err_o   (sb_err_o)
    );

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        if_valid_i = 1'b1;
        if_instr_i = instr;
        if_pc_i    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_we_i   = en;
        wb_rd_i   = rd;
        wb_data_i = data;
    endtask

    initial begin
        n_rst      = 1'b0;
        if_valid_i = 1'b0;
        if_instr_i = '0;
        if_pc_i    = '0;
        flush_i    = 1'b0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        wb_we_i    = 1'b0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
        ex_ready_i = 1'b1;

        // 1. Reset state and single ADDI x1,x0,5 issue
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ex_valid", 32'(ex_valid_o), 32'h0);
        check("rst_ex_pc",    ex_pc_o,         32'h0);
        check("rst_sb_err",   32'(sb_err_o),   32'h0);
        n_rst = 1'b1;
        #1;
        check("rst_if_ready", 32'(if_ready_o), 32'h1);
        offer(enc_addi(5'd1, 5'd0, 12'd5), 32'h0);
        #1;
        check("t1_if_ready", 32'(if_ready_o), 32'h1);
        check("t1_rs1_addr", 32'(rs1_addr_o), 32'h0);
        tick();
        check("t1_ex_valid", 32'(ex_valid_o), 32'h1);
        check("t1_ex_rd",    32'(ex_rd_o),    32'h1);
        check("t1_ex_rd_we", 32'(ex_rd_we_o), 32'h1);
        check("t1_ex_rs1",   ex_rs1_o,        32'h0);
        check("t1_ex_instr", ex_instr_o,      32'h00500093);

        // 2. ADD x2,x1,x1 stalls on x1 until writeback, then bypasses
        offer(enc_add(5'd2, 5'd1, 5'd1), 32'h4);
        #1;
        check("t2_raw_slot", 32'(if_ready_o), 32'h0);
        tick();
        check("t2_slot_empty", 32'(ex_valid_o), 32'h0);
        check("t2_raw_pend",   32'(if_ready_o), 32'h0);
        tick();
        check("t2_raw_pend2",  32'(if_ready_o), 32'h0);
        wb(1'b1, 5'd1, 32'h5);
        rs1_data_i = 32'hDEAD_BEEF;
        rs2_data_i = 32'hDEAD_BEEF;
        #1;
        check("t2_ready_wb", 32'(if_ready_o), 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        rs1_data_i = '0;
        rs2_data_i = '0;
        if_valid_i = 1'b0;
        check("t2_ex_rs1", ex_rs1_o,       32'h5);
        check("t2_ex_rs2", ex_rs2_o,       32'h5);
        check("t2_ex_rd",  32'(ex_rd_o),   32'h2);
        check("t2_ex_pc",  ex_pc_o,        32'h4);

        // 3. Back-pressure holds the slot for three cycles
        ex_ready_i = 1'b0;
        offer(enc_addi(5'd4, 5'd0, 12'd7), 32'h8);
        #1;
        check("t3_ready_full", 32'(if_ready_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_valid", 32'(ex_valid_o), 32'h1);
            check("t3_hold_pc",    ex_pc_o,         32'h4);
            check("t3_hold_rs1",   ex_rs1_o,        32'h5);
            check("t3_hold_ready", 32'(if_ready_o), 32'h0);
        end
        ex_ready_i = 1'b1;
        #1;
        check("t3_ready_release", 32'(if_ready_o), 32'h1);
        tick();
        check("t3_next_pc", ex_pc_o,      32'h8);
        check("t3_next_rd", 32'(ex_rd_o), 32'h4);
        if_valid_i = 1'b0;
        if_instr_i = enc_add(5'd9, 5'd2, 5'd0);
        #1;
        check("t3_x2_pending", 32'(if_ready_o), 32'h0);
        tick();
        wb(1'b1, 5'd2, 32'h1);
        tick();
        wb(1'b1, 5'd4, 32'h7);
        tick();
        wb(1'b0, 5'd0, 32'h0);

        // 4. Counter saturation on x3 with PEND_W=2
        offer(enc_addi(5'd3, 5'd0, 12'd1), 32'h10);
        tick();
        offer(enc_addi(5'd3, 5'd0, 12'd2), 32'h14);
        tick();
        offer(enc_addi(5'd3, 5'd0, 12'd3), 32'h18);
        tick();
        check("t4_third_pc", ex_pc_o, 32'h18);
        offer(enc_addi(5'd3, 5'd0, 12'd4), 32'h1C);
        #1;
        check("t4_sat_slot", 32'(if_ready_o), 32'h0);
        tick();
        check("t4_sat_a", 32'(if_ready_o), 32'h0);
        tick();
        check("t4_sat_b", 32'(if_ready_o), 32'h0);
        wb(1'b1, 5'd3, 32'h1);
        #1;
        check("t4_sat_wb_cycle", 32'(if_ready_o), 32'h0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        #1;
        check("t4_sat_released", 32'(if_ready_o), 32'h1);
        tick();
        if_valid_i = 1'b0;
        check("t4_fourth_valid", 32'(ex_valid_o), 32'h1);
        check("t4_fourth_pc",    ex_pc_o,         32'h1C);
        check("t4_fourth_rd",    32'(ex_rd_o),    32'h3);
        tick();
        wb(1'b1, 5'd3, 32'h2);
        repeat (3) tick();
        wb(1'b0, 5'd0, 32'h0);
        check("t4_no_err", 32'(sb_err_o), 32'h0);

        // 5. Flush squashes the full slot and blocks the offered instruction
        ex_ready_i = 1'b0;
        offer(enc_addi(5'd5, 5'd0, 12'd9), 32'h20);
        tick();
        check("t5_slot_full", 32'(ex_valid_o), 32'h1);
        offer(enc_addi(5'd6, 5'd0, 12'd1), 32'h24);
        flush_i    = 1'b1;
        ex_ready_i = 1'b1;
        #1;
        check("t5_flush_ready", 32'(if_ready_o), 32'h0);
        tick();
        check("t5_flush_valid", 32'(ex_valid_o), 32'h0);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if_instr_i = enc_add(5'd7, 5'd5, 5'd0);
        #1;
        check("t5_x5_not_pending", 32'(if_ready_o), 32'h1);

        // 6. Scoreboard error, then async reset during a stall
        wb(1'b1, 5'd0, 32'h1234);
        tick();
        check("t6_wb_x0_no_err", 32'(sb_err_o), 32'h0);
        wb(1'b1, 5'd7, 32'h1234);
        tick();
        check("t6_err_set", 32'(sb_err_o), 32'h1);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        check("t6_err_sticky", 32'(sb_err_o), 32'h1);

        offer(enc_addi(5'd1, 5'd0, 12'd1), 32'h40);
        tick();
        if_valid_i = 1'b0;
        tick();
        ex_ready_i = 1'b0;
        offer(enc_addi(5'd8, 5'd0, 12'd2), 32'h44);
        tick();
        offer(enc_add(5'd2, 5'd1, 5'd1), 32'h48);
        #1;
        check("t6_stall", 32'(if_ready_o), 32'h0);
        #2;
        n_rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ex_valid_o), 32'h0);
        check("t6_rst_pc",    ex_pc_o,         32'h0);
        check("t6_rst_instr", ex_instr_o,      32'h0);
        check("t6_rst_rs1",   ex_rs1_o,        32'h0);
        check("t6_rst_rd",    32'(ex_rd_o),    32'h0);
        check("t6_rst_rd_we", 32'(ex_rd_we_o), 32'h0);
        check("t6_rst_err",   32'(sb_err_o),   32'h0);
        if_valid_i = 1'b0;
        #1;
        n_rst = 1'b1;
        #1;
        check("t6_pend_cleared", 32'(if_ready_o), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
